cache_way_store: RTL and testbench
==================================

// Module: cache_way_store
// PURPOSE
//  One way of a direct-indexed cache. Holds per-set tag, valid and dirty bits
//  plus a 2^s_offset-byte data line. Includes a CPU-word <-> line bus adapter.
//  Sits under the cache controller; the controller owns all FSM and pmem
//  handshaking; this block only stores, reads, merges and compares.
// PARAMETERS
//  s_offset  5                      byte-offset bits; line = 2^s_offset bytes (32)
//  s_index   3                      set-index bits; num_sets = 2^s_index (8)
//  s_tag     32-s_offset-s_index    tag width (24)
//  s_mask    2**s_offset            byte enables per line (32)
//  s_line    8*s_mask               line width in bits (256)
// PORTS
//  clk              in   1        rising-edge clock
//  reset            in   1        synchronous, active-high
//  read             in   1        read enable; updates registered outputs
//  address          in   32       CPU byte address; tag=[31:8], index=[7:5], word=[4:2]
//  tag_load         in   1        write tag=address tag, valid=1 at index
//  dirty_load       in   1        write dirty_in at index
//  dirty_in         in   1        dirty value
//  line_load        in   1        full-line fill from line_in
//  cpu_write        in   1        byte-enabled word write from mem_wdata
//  line_in          in   s_line   fill data from physical memory
//  mem_wdata        in   32       CPU write word
//  mem_byte_enable  in   4        CPU byte enables; bit i -> byte i of word
//  tag_out          out  s_tag    stored tag (registered)
//  valid_out        out  1        stored valid (registered)
//  dirty_out        out  1        stored dirty (registered)
//  line_out         out  s_line   stored line (registered), for write-back
//  mem_rdata        out  32       word of line_out selected by address[4:2]
//  hit              out  1        valid_out && (tag_out == address[31:8]), combinational
// BEHAVIOUR
//  - Reset: all tag/valid/dirty/data storage and all registered outputs -> 0.
//    Reset has priority over every other input.
//  - Writes commit on posedge clk at set address[7:5]:
//    - tag_load: tag <= address tag, valid <= 1.
//    - dirty_load: dirty <= dirty_in.
//  - Data write enable is 32 bits wide:
//    - line_load: all ones, data = line_in.
//    - else cpu_write: mem_byte_enable shifted left by 4*address[4:2],
//      data = {8{mem_wdata}}.
//    - line_load wins when both are asserted.
//    - Only enabled bytes change.
//  - Read: when read=1 the outputs register the entry at the current index,
//    one-cycle latency. When read=0 the outputs hold their value.
//  - Same-cycle read+write to same index is write-first:
//    - outputs show the post-write value (per-byte merge for data).
//  - mem_rdata = line_out[32*address[4:2] +: 32], combinational.
//    Depends on the live address.
//  - Index wrap: index 7 and index 0 are independent; no aliasing.
//  - Writes with read=0 still commit; outputs unchanged until next read.
//  - Widths: all compares are unsigned and exact; no truncation of the tag.
// STRUCTURE
//  - Package cache_pkg: s_offset/s_index/s_tag/s_line localparams and the
//    address field-extraction functions (tag_of, index_of, word_of).
//  - One sub-module meta_ram #(width): num_sets x width storage, sync reset,
//    write-first registered read. Instantiated for tag, valid and dirty.
//  - Data line array and bus adapter are inline in this module.
// TESTING
//  - Reset, then read=1 at addr 0x0000_0020 -> valid_out=0, dirty_out=0,
//    hit=0, line_out=0.
//  - Fill: addr 0xABCDEF40, tag_load=1, line_load=1, line_in=word i is 0x1111_1111*i,
//    read=1 -> next cycle hit=1, tag_out=0xABCDEF.
//    Sweep addr[4:2]=0..7 -> mem_rdata = 0x0,0x11111111,...,0x77777777.
//  - CPU write: addr 0xABCDEF48, mem_wdata=0xDEADBEEF, byte_en=4'b0101,
//    cpu_write=1, dirty_load=1, dirty_in=1, read=1 -> mem_rdata=0x22AD22EF,
//    dirty_out=1, other words unchanged.
//  - Simultaneous line_load+cpu_write -> line equals line_in exactly.
//    Same-cycle read returns new data.
//  - Index isolation: fill set 7 tag 0x000001, then read set 0 ->
//    valid_out=0. Read 0x000001E0 -> hit=1.
//  - Tag mismatch/hold/mid-op reset:
//    - same index, different tag -> hit=0.
//    - read=0 while writing -> outputs hold.
//    - reset asserted with tag_load -> entry stays invalid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry and address-field helpers for the cache way store.
package cache_pkg;

  localparam int s_offset        = 5;
  localparam int s_index         = 3;
  localparam int s_tag           = 32 - s_offset - s_index;
  localparam int s_mask          = 2 ** s_offset;
  localparam int s_line          = 8 * s_mask;
  localparam int num_sets        = 2 ** s_index;
  localparam int words_per_line  = s_mask / 4;
  localparam int s_word          = s_offset - 2;

  // Upper address bits form the tag, compared in full width.
  function automatic logic [s_tag-1:0] tag_of(input logic [31:0] addr);
    return addr[31 -: s_tag];
  endfunction

  // Set index sits directly above the byte offset.
  function automatic logic [s_index-1:0] index_of(input logic [31:0] addr);
    return addr[s_offset +: s_index];
  endfunction

  // 32-bit word position within the line.
  function automatic logic [s_word-1:0] word_of(input logic [31:0] addr);
    return addr[s_offset-1:2];
  endfunction

endpackage

// File: rtl/cache_way_store_meta_ram.sv
// Small per-set storage for tag/valid/dirty metadata with a write-first,
// registered read port.
module meta_ram
  import cache_pkg::*;
#(
  parameter int width = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               we,
  input  logic [s_index-1:0] index,
  input  logic [width-1:0]   wdata,
  output logic [width-1:0]   rdata
);

  logic [width-1:0] mem [num_sets];

  // Storage update and registered read; a same-cycle write is forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < num_sets; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[index] <= wdata;
      end
      if (read) begin
        rdata <= we ? wdata : mem[index];
      end
    end
  end

endmodule

// File: rtl/cache_way_store.sv
// One way of a direct-indexed cache: metadata, data lines and the
// CPU-word <-> line adapter. Control and memory handshaking live elsewhere.
module cache_way_store
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic [31:0]         address,
  input  logic                tag_load,
  input  logic                dirty_load,
  input  logic                dirty_in,
  input  logic                line_load,
  input  logic                cpu_write,
  input  logic [s_line-1:0]   line_in,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_byte_enable,
  output logic [s_tag-1:0]    tag_out,
  output logic                valid_out,
  output logic                dirty_out,
  output logic [s_line-1:0]   line_out,
  output logic [31:0]         mem_rdata,
  output logic                hit
);

  logic [s_index-1:0] index;
  logic [s_word-1:0]  word;
  logic [s_mask-1:0]  byte_en;
  logic [s_line-1:0]  wline;
  logic [s_line-1:0]  merged;
  logic [s_line-1:0]  data [num_sets];

  assign index = index_of(address);
  assign word  = word_of(address);

  meta_ram #(.width(s_tag)) u_tag (
    .clk   (clk),
    .reset (reset),
    .read  (read),
    .we    (tag_load),
    .index (index),
    .wdata (tag_of(address)),
    .rdata (tag_out)
  );

  meta_ram #(.width(1)) u_valid (
    .clk   (clk),
    .reset (reset),
    .read  (read),
    .we    (tag_load),
    .index (index),
    .wdata (1'b1),
    .rdata (valid_out)
  );

  meta_ram #(.width(1)) u_dirty (
    .clk   (clk),
    .reset (reset),
    .read  (read),
    .we    (dirty_load),
    .index (index),
    .wdata (dirty_in),
    .rdata (dirty_out)
  );

  // Bus adapter: a fill overrides a CPU write; CPU word is replicated across the line.
  always_comb begin
    byte_en = '0;
    wline   = '0;
    if (line_load) begin
      byte_en = {s_mask{1'b1}};
      wline   = line_in;
    end else if (cpu_write) begin
      byte_en = s_mask'(mem_byte_enable) << {word, 2'b00};
      wline   = {words_per_line{mem_wdata}};
    end else begin
      byte_en = '0;
      wline   = '0;
    end
  end

  // Per-byte merge of new data over the stored line (also the write-first read value).
  always_comb begin
    merged = data[index];
    for (int b = 0; b < s_mask; b++) begin
      if (byte_en[b]) begin
        merged[8*b +: 8] = wline[8*b +: 8];
      end else begin
        merged[8*b +: 8] = data[index][8*b +: 8];
      end
    end
  end

  // Line storage and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < num_sets; i++) begin
        data[i] <= '0;
      end
      line_out <= '0;
    end else begin
      if (|byte_en) begin
        data[index] <= merged;
      end
      if (read) begin
        line_out <= merged;
      end
    end
  end

  assign mem_rdata = line_out[32*word +: 32];
  assign hit       = valid_out && (tag_out == tag_of(address));

endmodule

// File: tb/tb_cache_way_store.sv
// Scoreboard bench for cache_way_store: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_cache_way_store;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               read = 1'b0;
  logic [31:0]        address = 32'h0;
  logic               tag_load = 1'b0;
  logic               dirty_load = 1'b0;
  logic               dirty_in = 1'b0;
  logic               line_load = 1'b0;
  logic               cpu_write = 1'b0;
  logic [s_line-1:0]  line_in = '0;
  logic [31:0]        mem_wdata = 32'h0;
  logic [3:0]         mem_byte_enable = 4'h0;
  logic [s_tag-1:0]   tag_out;
  logic               valid_out;
  logic               dirty_out;
  logic [s_line-1:0]  line_out;
  logic [31:0]        mem_rdata;
  logic               hit;

  cache_way_store dut (
    .clk(clk), .reset(reset), .read(read), .address(address),
    .tag_load(tag_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
    .line_load(line_load), .cpu_write(cpu_write), .line_in(line_in),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out),
    .line_out(line_out), .mem_rdata(mem_rdata), .hit(hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [5:0]        mask;  // [0]tag [1]valid [2]dirty [3]line [4]rdata [5]hit
    logic [s_tag-1:0]  tag;
    logic              valid;
    logic              dirty;
    logic [s_line-1:0] line;
    logic [31:0]       rdata;
    logic              hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  logic chk_pend = 1'b0;
  logic obs = 1'b0;

  // The cycle that sampled a checked operation presents its response afterwards.
  always @(posedge clk) obs <= chk_pend;

  task automatic cmp(input string nm, input string fld, input logic [s_line-1:0] act,
                     input logic [s_line-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pop and compare on every presented response.
  always @(negedge clk) begin
    if (obs) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL no_expectation actual=response expected=none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.mask[0]) cmp(e.name, "tag",   s_line'(tag_out),   s_line'(e.tag));
        if (e.mask[1]) cmp(e.name, "valid", s_line'(valid_out), s_line'(e.valid));
        if (e.mask[2]) cmp(e.name, "dirty", s_line'(dirty_out), s_line'(e.dirty));
        if (e.mask[3]) cmp(e.name, "line",  line_out,           e.line);
        if (e.mask[4]) cmp(e.name, "rdata", s_line'(mem_rdata), s_line'(e.rdata));
        if (e.mask[5]) cmp(e.name, "hit",   s_line'(hit),       s_line'(e.hit));
      end
    end
  end

  task automatic push(input string nm, input logic [5:0] m, input logic [s_tag-1:0] t,
                      input logic v, input logic d, input logic [s_line-1:0] l,
                      input logic [31:0] r, input logic h);
    exp_t e;
    e.name = nm; e.mask = m; e.tag = t; e.valid = v; e.dirty = d;
    e.line = l; e.rdata = r; e.hit = h;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the address is held until the response is checked.
  task automatic op(input logic [31:0] a, input logic rst, input logic rd,
                    input logic tl, input logic dl, input logic di,
                    input logic ll, input logic cw, input logic [s_line-1:0] lin,
                    input logic [31:0] wd, input logic [3:0] be, input logic chk);
    @(negedge clk);
    #1;
    address = a; reset = rst; read = rd; tag_load = tl; dirty_load = dl;
    dirty_in = di; line_load = ll; cpu_write = cw; line_in = lin;
    mem_wdata = wd; mem_byte_enable = be; chk_pend = chk;
    @(posedge clk);
    #1;
    reset = 1'b0; read = 1'b0; tag_load = 1'b0; dirty_load = 1'b0;
    line_load = 1'b0; cpu_write = 1'b0; chk_pend = 1'b0;
  endtask

  logic [s_line-1:0] fill_line;
  logic [s_line-1:0] l2_line;
  logic [s_line-1:0] cw_line;
  logic [s_line-1:0] zero_line;
  localparam logic [5:0] ALL = 6'b111111;

  initial begin
    zero_line = '0;
    for (int i = 0; i < 8; i++) begin
      fill_line[32*i +: 32] = 32'h1111_1111 * i;
      l2_line[32*i +: 32]   = 32'hC0DE_0000 | i;
    end
    cw_line = fill_line;
    cw_line[95:64] = 32'h22AD_22EF;

    // Reset with read asserted: everything clears.
    push("reset", ALL, 24'h0, 1'b0, 1'b0, zero_line, 32'h0, 1'b0);
    op(32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);
    push("post_reset_read", ALL, 24'h0, 1'b0, 1'b0, zero_line, 32'h0, 1'b0);
    op(32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    // Fill set 2 with read in the same cycle.
    push("fill", ALL, 24'hABCDEF, 1'b1, 1'b0, fill_line, 32'h0, 1'b1);
    op(32'hABCD_EF40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fill_line, 32'h0, 4'h0, 1'b1);

    // Word sweep across the line.
    for (int w = 0; w < 8; w++) begin
      push($sformatf("sweep%0d", w), 6'b110000, 24'h0, 1'b0, 1'b0, zero_line,
           32'h1111_1111 * w, 1'b1);
      op(32'hABCD_EF40 | (w << 2), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         zero_line, 32'h0, 4'h0, 1'b1);
    end

    // Byte-enabled CPU write with dirty set, write-first read.
    push("cpu_write", ALL, 24'hABCDEF, 1'b1, 1'b1, cw_line, 32'h22AD_22EF, 1'b1);
    op(32'hABCD_EF48, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, zero_line,
       32'hDEAD_BEEF, 4'b0101, 1'b1);
    push("cpu_write_w1", 6'b110100, 24'h0, 1'b0, 1'b1, zero_line, 32'h1111_1111, 1'b1);
    op(32'hABCD_EF44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);
    push("cpu_write_w3", 6'b110000, 24'h0, 1'b0, 1'b0, zero_line, 32'h3333_3333, 1'b1);
    op(32'hABCD_EF4C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    // Fill and CPU write together: the fill wins in every byte.
    push("fill_beats_cpu", ALL, 24'hABCDEF, 1'b1, 1'b1, l2_line, 32'hC0DE_0001, 1'b1);
    op(32'hABCD_EF44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, l2_line,
       32'hFFFF_FFFF, 4'hF, 1'b1);

    // Set 7 fill without read, then set 0 stays empty.
    op(32'h0000_01E0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fill_line, 32'h0, 4'h0, 1'b0);
    push("set0_empty", ALL, 24'h0, 1'b0, 1'b0, zero_line, 32'h0, 1'b0);
    op(32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);
    push("set7_hit", ALL, 24'h000001, 1'b1, 1'b0, fill_line, 32'h0, 1'b1);
    op(32'h0000_01E0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);
    push("set2_intact", ALL, 24'hABCDEF, 1'b1, 1'b1, l2_line, 32'hC0DE_0000, 1'b1);
    op(32'hABCD_EF40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    // Same index, different tag.
    push("tag_miss", ALL, 24'hABCDEF, 1'b1, 1'b1, l2_line, 32'hC0DE_0000, 1'b0);
    op(32'h1234_5640, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    // Write with read low: outputs hold, write still commits.
    push("hold", ALL, 24'hABCDEF, 1'b1, 1'b1, l2_line, 32'hC0DE_0000, 1'b0);
    op(32'h1234_5640, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);
    push("hold_committed", 6'b100011, 24'h123456, 1'b1, 1'b0, zero_line, 32'h0, 1'b1);
    op(32'h1234_5640, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    // Reset beats a concurrent tag_load.
    push("reset_vs_load", ALL, 24'h0, 1'b0, 1'b0, zero_line, 32'h0, 1'b0);
    op(32'h5555_5560, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fill_line, 32'h0, 4'h0, 1'b1);
    push("after_reset_load", ALL, 24'h0, 1'b0, 1'b0, zero_line, 32'h0, 1'b0);
    op(32'h5555_5560, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zero_line, 32'h0, 4'h0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
